// File: rtl/syn_pcm_buffer_if.sv
// Ingress, reader and status signals of the ping-pong PCM sample buffer.
// master = sample source / FFT reader side, slave = the buffer itself.
interface syn_pcm_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              pcm_valid_ih;
  logic [DATA_W-1:0] pcm_lsample_id;
  logic [DATA_W-1:0] pcm_rsample_id;
  logic              pcm_lchnnl_rden_ih;
  logic [ADDR_W-1:0] pcm_lchnnl_addr_id;
  logic [DATA_W-1:0] pcm_lchnnl_rdata_od;
  logic              pcm_lchnnl_rd_valid_oh;
  logic              pcm_rchnnl_rden_ih;
  logic [ADDR_W-1:0] pcm_rchnnl_addr_id;
  logic [DATA_W-1:0] pcm_rchnnl_rdata_od;
  logic              pcm_rchnnl_rd_valid_oh;
  logic              pcm_rdy_oh;
  logic              pcm_done_ih;
  logic              ovrflw_oh;
  logic              ovrflw_clr_ih;
  logic [15:0]       ovrflw_cnt_od;
  logic [ADDR_W:0]   fill_lvl_od;

  modport master (
    output pcm_valid_ih, pcm_lsample_id, pcm_rsample_id,
    output pcm_lchnnl_rden_ih, pcm_lchnnl_addr_id,
    output pcm_rchnnl_rden_ih, pcm_rchnnl_addr_id,
    output pcm_done_ih, ovrflw_clr_ih,
    input  pcm_lchnnl_rdata_od, pcm_lchnnl_rd_valid_oh,
    input  pcm_rchnnl_rdata_od, pcm_rchnnl_rd_valid_oh,
    input  pcm_rdy_oh, ovrflw_oh, ovrflw_cnt_od, fill_lvl_od
  );

  modport slave (
    input  pcm_valid_ih, pcm_lsample_id, pcm_rsample_id,
    input  pcm_lchnnl_rden_ih, pcm_lchnnl_addr_id,
    input  pcm_rchnnl_rden_ih, pcm_rchnnl_addr_id,
    input  pcm_done_ih, ovrflw_clr_ih,
    output pcm_lchnnl_rdata_od, pcm_lchnnl_rd_valid_oh,
    output pcm_rchnnl_rdata_od, pcm_rchnnl_rd_valid_oh,
    output pcm_rdy_oh, ovrflw_oh, ovrflw_cnt_od, fill_lvl_od
  );
endinterface

// File: rtl/syn_pcm_buffer.sv
// Ping-pong stereo PCM buffer: one bank fills while the other is frozen for the reader.
// Optional dropped-sample counter enabled by defining SYN_PCM_BUF_OVRFLW_CNT_EN.
module syn_pcm_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input logic              clk_ir,
  input logic              rst_sync,
  syn_pcm_buffer_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WORDS = 2 * DEPTH;

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state_reg, state_next;
  logic              wr_bank_reg, wr_bank_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic              pcm_rdy_reg, pcm_rdy_next;
  logic              ovrflw_reg;
  logic              wr_en;
  logic              drop;
  logic              rd_bank;

  assign rd_bank = ~wr_bank_reg;

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state_reg   <= FILL;
      wr_bank_reg <= 1'b0;
      wr_ptr_reg  <= '0;
      pcm_rdy_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_bank_reg <= wr_bank_next;
      wr_ptr_reg  <= wr_ptr_next;
      pcm_rdy_reg <= pcm_rdy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wr_bank_next = wr_bank_reg;
    wr_ptr_next  = wr_ptr_reg;
    pcm_rdy_next = pcm_rdy_reg;
    wr_en        = 1'b0;
    drop         = 1'b0;
    case (state_reg)
      FILL: begin
        if (bus.pcm_done_ih) pcm_rdy_next = 1'b0;
        if (bus.pcm_valid_ih) begin
          wr_en = 1'b1;
          if (&wr_ptr_reg) begin
            // A release in the same cycle frees the reader bank just in time to swap.
            if (!pcm_rdy_reg || bus.pcm_done_ih) begin
              wr_bank_next = ~wr_bank_reg;
              wr_ptr_next  = '0;
              pcm_rdy_next = 1'b1;
            end else begin
              state_next = HOLD;
            end
          end else begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
          end
        end
      end
      HOLD: begin
        drop = bus.pcm_valid_ih;
        if (bus.pcm_done_ih) begin
          wr_bank_next = ~wr_bank_reg;
          wr_ptr_next  = '0;
          pcm_rdy_next = 1'b1;
          state_next   = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Both channels share write address/enable and differ only in data and read port.
  logic [DATA_W-1:0] ch_wdata  [2];
  logic              ch_rden   [2];
  logic [ADDR_W-1:0] ch_addr   [2];
  logic [DATA_W-1:0] ch_rdata  [2];
  logic              ch_rvalid [2];

  assign ch_wdata[0] = bus.pcm_lsample_id;
  assign ch_wdata[1] = bus.pcm_rsample_id;
  assign ch_rden[0]  = bus.pcm_lchnnl_rden_ih;
  assign ch_rden[1]  = bus.pcm_rchnnl_rden_ih;
  assign ch_addr[0]  = bus.pcm_lchnnl_addr_id;
  assign ch_addr[1]  = bus.pcm_rchnnl_addr_id;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [DATA_W-1:0] mem [0:WORDS-1];
      logic [DATA_W-1:0] rdata_reg;
      logic              rvalid_reg;

      always_ff @(posedge clk_ir) begin
        if (wr_en) mem[{wr_bank_reg, wr_ptr_reg}] <= ch_wdata[gi];
      end

      always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= ch_rden[gi];
          if (ch_rden[gi]) rdata_reg <= pcm_rdy_reg ? mem[{rd_bank, ch_addr[gi]}] : '0;
        end
      end

      assign ch_rdata[gi]  = rdata_reg;
      assign ch_rvalid[gi] = rvalid_reg;
    end
  endgenerate

  assign bus.pcm_lchnnl_rdata_od    = ch_rdata[0];
  assign bus.pcm_lchnnl_rd_valid_oh = ch_rvalid[0];
  assign bus.pcm_rchnnl_rdata_od    = ch_rdata[1];
  assign bus.pcm_rchnnl_rd_valid_oh = ch_rvalid[1];

  // Clear wins over a drop in the same cycle.
  always_ff @(posedge clk_ir) begin
    if (rst_sync || bus.ovrflw_clr_ih) ovrflw_reg <= 1'b0;
    else if (drop)                     ovrflw_reg <= 1'b1;
  end

`ifdef SYN_PCM_BUF_OVRFLW_CNT_EN
  logic [15:0] ovrflw_cnt_reg;

  always_ff @(posedge clk_ir) begin
    if (rst_sync || bus.ovrflw_clr_ih)  ovrflw_cnt_reg <= '0;
    else if (drop && !(&ovrflw_cnt_reg)) ovrflw_cnt_reg <= ovrflw_cnt_reg + 16'd1;
  end

  assign bus.ovrflw_cnt_od = ovrflw_cnt_reg;
`else
  assign bus.ovrflw_cnt_od = 16'd0;
`endif

  assign bus.pcm_rdy_oh  = pcm_rdy_reg;
  assign bus.ovrflw_oh   = ovrflw_reg;
  assign bus.fill_lvl_od = (state_reg == HOLD) ? (ADDR_W + 1)'(DEPTH) : {1'b0, wr_ptr_reg};
endmodule

// File: tb/tb_syn_pcm_buffer.sv
// Directed bench for syn_pcm_buffer: read vector table plus hand-written fill/hold/release sequences.
// Expected counter values follow SYN_PCM_BUF_OVRFLW_CNT_EN.
module tb_syn_pcm_buffer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
`ifdef SYN_PCM_BUF_OVRFLW_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  syn_pcm_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  syn_pcm_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_ir   (clk),
    .rst_sync (rst),
    .bus      (bus)
  );

  typedef struct {
    logic        l_en;
    logic [6:0]  l_addr;
    logic        r_en;
    logic [6:0]  r_addr;
    logic        l_vld;
    logic [31:0] l_data;
    logic        r_vld;
    logic [31:0] r_data;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    bus.pcm_valid_ih   = 1'b1;
    bus.pcm_lsample_id = l;
    bus.pcm_rsample_id = r;
    tick();
    bus.pcm_valid_ih   = 1'b0;
  endtask

  task automatic push_n(input int base, input int n);
    for (int k = 0; k < n; k++) push(32'(base + k), 32'(32'h1000 + base + k));
  endtask

  task automatic rd(input logic le, input logic [6:0] la, input logic re, input logic [6:0] ra);
    bus.pcm_lchnnl_rden_ih = le;
    bus.pcm_lchnnl_addr_id = la;
    bus.pcm_rchnnl_rden_ih = re;
    bus.pcm_rchnnl_addr_id = ra;
    tick();
    bus.pcm_lchnnl_rden_ih = 1'b0;
    bus.pcm_rchnnl_rden_ih = 1'b0;
    $display("read L%0b@%0d R%0b@%0d -> L v%0b 0x%0h, R v%0b 0x%0h", le, la, re, ra,
             bus.pcm_lchnnl_rd_valid_oh, bus.pcm_lchnnl_rdata_od,
             bus.pcm_rchnnl_rd_valid_oh, bus.pcm_rchnnl_rdata_od);
  endtask

  task automatic rd_check(input string name, input logic [6:0] la, input logic [31:0] le,
                          input logic [6:0] ra, input logic [31:0] re);
    rd(1'b1, la, 1'b1, ra);
    check({name, "_lv"}, 32'(bus.pcm_lchnnl_rd_valid_oh), 32'd1);
    check({name, "_l"},  bus.pcm_lchnnl_rdata_od, le);
    check({name, "_rv"}, 32'(bus.pcm_rchnnl_rd_valid_oh), 32'd1);
    check({name, "_r"},  bus.pcm_rchnnl_rdata_od, re);
  endtask

  task automatic pulse_done();
    bus.pcm_done_ih = 1'b1;
    tick();
    bus.pcm_done_ih = 1'b0;
  endtask

  task automatic check_status(input string name, input logic rdy, input logic ov,
                              input logic [15:0] cnt, input logic [7:0] fill);
    check({name, "_rdy"},  32'(bus.pcm_rdy_oh), 32'(rdy));
    check({name, "_ovf"},  32'(bus.ovrflw_oh), 32'(ov));
    check({name, "_cnt"},  32'(bus.ovrflw_cnt_od), 32'(cnt));
    check({name, "_fill"}, 32'(bus.fill_lvl_od), 32'(fill));
  endtask

  initial begin
    bus.pcm_valid_ih       = 1'b0;
    bus.pcm_lsample_id     = '0;
    bus.pcm_rsample_id     = '0;
    bus.pcm_lchnnl_rden_ih = 1'b0;
    bus.pcm_lchnnl_addr_id = '0;
    bus.pcm_rchnnl_rden_ih = 1'b0;
    bus.pcm_rchnnl_addr_id = '0;
    bus.pcm_done_ih        = 1'b0;
    bus.ovrflw_clr_ih      = 1'b0;

    // Read vectors against the first full bank (left=i, right=0x1000+i), issued back to back.
    vecs[0] = '{1'b1, 7'd5,   1'b1, 7'd127, 1'b1, 32'd5,   1'b1, 32'h107F};
    vecs[1] = '{1'b1, 7'd0,   1'b0, 7'd0,   1'b1, 32'd0,   1'b0, 32'h0};
    vecs[2] = '{1'b0, 7'd0,   1'b1, 7'd0,   1'b0, 32'd0,   1'b1, 32'h1000};
    vecs[3] = '{1'b1, 7'd127, 1'b1, 7'd64,  1'b1, 32'd127, 1'b1, 32'h1040};
    vecs[4] = '{1'b1, 7'd64,  1'b1, 7'd1,   1'b1, 32'd64,  1'b1, 32'h1001};
    vecs[5] = '{1'b0, 7'd9,   1'b0, 7'd9,   1'b0, 32'd0,   1'b0, 32'h0};

    tick();
    tick();
    rst = 1'b0;
    check_status("reset", 1'b0, 1'b0, 16'd0, 8'd0);
    check("reset_lv", 32'(bus.pcm_lchnnl_rd_valid_oh), 32'd0);
    check("reset_rv", 32'(bus.pcm_rchnnl_rd_valid_oh), 32'd0);
    check("reset_ld", bus.pcm_lchnnl_rdata_od, 32'd0);
    check("reset_rd", bus.pcm_rchnnl_rdata_od, 32'd0);

    // Not ready: reads return zero with valid; release is ignored.
    rd_check("rd_notrdy", 7'd3, 32'd0, 7'd3, 32'd0);
    pulse_done();
    check_status("done_idle", 1'b0, 1'b0, 16'd0, 8'd0);

    push_n(0, 127);
    check_status("fill127", 1'b0, 1'b0, 16'd0, 8'd127);
    push_n(127, 1);
    check_status("bank0_full", 1'b1, 1'b0, 16'd0, 8'd0);

    for (int v = 0; v < 6; v++) begin
      rd(vecs[v].l_en, vecs[v].l_addr, vecs[v].r_en, vecs[v].r_addr);
      check($sformatf("vec%0d_lv", v), 32'(bus.pcm_lchnnl_rd_valid_oh), 32'(vecs[v].l_vld));
      check($sformatf("vec%0d_rv", v), 32'(bus.pcm_rchnnl_rd_valid_oh), 32'(vecs[v].r_vld));
      if (vecs[v].l_vld) check($sformatf("vec%0d_l", v), bus.pcm_lchnnl_rdata_od, vecs[v].l_data);
      if (vecs[v].r_vld) check($sformatf("vec%0d_r", v), bus.pcm_rchnnl_rdata_od, vecs[v].r_data);
    end

    // Filling the other bank must not disturb the held bank.
    push_n(128, 64);
    rd_check("held_rd", 7'd0, 32'd0, 7'd0, 32'h1000);
    check_status("half1", 1'b1, 1'b0, 16'd0, 8'd64);

    push_n(192, 64);
    check_status("hold", 1'b1, 1'b0, 16'd0, 8'd128);
    push_n(256, 10);
    check_status("drops", 1'b1, 1'b1, CNT_EN ? 16'd10 : 16'd0, 8'd128);
    rd_check("hold_rd", 7'd5, 32'd5, 7'd127, 32'h107F);

    pulse_done();
    check_status("release", 1'b1, 1'b1, CNT_EN ? 16'd10 : 16'd0, 8'd0);
    rd_check("bank1_rd", 7'd0, 32'd128, 7'd127, 32'h10FF);
    rd_check("bank1_mid", 7'd64, 32'd192, 7'd10, 32'h108A);

    bus.ovrflw_clr_ih = 1'b1;
    tick();
    bus.ovrflw_clr_ih = 1'b0;
    check_status("clr", 1'b1, 1'b0, 16'd0, 8'd0);

    // Release arrives together with the last sample of the bank: swap without drop.
    push_n(300, 127);
    bus.pcm_done_ih = 1'b1;
    push(32'd427, 32'h1000 + 32'd427);
    bus.pcm_done_ih = 1'b0;
    check_status("swap_same", 1'b1, 1'b0, 16'd0, 8'd0);
    rd_check("swap_rd", 7'd0, 32'd300, 7'd127, 32'h1000 + 32'd427);

    // Clear beats a simultaneous drop; drop with release is counted.
    push_n(500, 128);
    check_status("hold2", 1'b1, 1'b0, 16'd0, 8'd128);
    bus.ovrflw_clr_ih = 1'b1;
    push(32'd999, 32'd999);
    bus.ovrflw_clr_ih = 1'b0;
    check_status("clr_prio", 1'b1, 1'b0, 16'd0, 8'd128);
    push(32'd998, 32'd998);
    check_status("drop1", 1'b1, 1'b1, CNT_EN ? 16'd1 : 16'd0, 8'd128);
    bus.pcm_done_ih = 1'b1;
    push(32'd997, 32'd997);
    bus.pcm_done_ih = 1'b0;
    check_status("drop_rel", 1'b1, 1'b1, CNT_EN ? 16'd2 : 16'd0, 8'd0);
    rd_check("bank1b_rd", 7'd3, 32'd503, 7'd127, 32'h1000 + 32'd627);

    // Release while filling clears ready; reads then return zero.
    pulse_done();
    check("rel_fill_rdy", 32'(bus.pcm_rdy_oh), 32'd0);
    rd_check("rel_fill_rd", 7'd3, 32'd0, 7'd3, 32'd0);

    // Reset mid-fill discards the partial bank.
    push_n(700, 50);
    check("pre_rst_fill", 32'(bus.fill_lvl_od), 32'd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_status("rst_mid", 1'b0, 1'b0, 16'd0, 8'd0);
    check("rst_mid_lv", 32'(bus.pcm_lchnnl_rd_valid_oh), 32'd0);
    check("rst_mid_ld", bus.pcm_lchnnl_rdata_od, 32'd0);
    push_n(32'h500, 128);
    check_status("refill", 1'b1, 1'b0, 16'd0, 8'd0);
    rd_check("refill_rd", 7'd0, 32'h500, 7'd49, 32'h1531);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
